// File: rtl/decoder_3_8_seq.sv
// -----------------------------------------------------------------------------
// decoder_3_8_seq
//   Registered, handshaked 3-to-8 one-hot decoder. Each accepted code drives
//   its one-hot bit on y for HOLD_CYCLES cycles, then y is released. A
//   one-entry pending buffer lets the next code queue up while the current
//   one is held, so back-to-back codes produce gap-free output.
//
// Parameters
//   HOLD_CYCLES : cycles each decoded value is held on y (1..255)
//   CW          : hold counter width, 2**CW > HOLD_CYCLES
//
// Ports
//   clk      : clock, rising-edge active
//   rst_n    : asynchronous active-low reset
//   clr      : synchronous abort of the held output and pending code
//   in_valid : upstream presents a code on in_code
//   in_code  : 3-bit binary code
//   in_ready : a code can be accepted this cycle (registered, pending empty)
//   y        : registered one-hot output (all-zero when idle)
//   y_valid  : high while a code is held (equals |y)
//   done     : high during the last hold cycle of each code
// -----------------------------------------------------------------------------
module decoder_3_8_seq #(
  parameter int HOLD_CYCLES = 4,
  parameter int CW          = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       in_valid,
  input  logic [2:0] in_code,
  output logic       in_ready,
  output logic [7:0] y,
  output logic       y_valid,
  output logic       done
);

  localparam logic [0:0]    S_IDLE    = 1'b0;
  localparam logic [0:0]    S_HOLD    = 1'b1;
  localparam logic [CW-1:0] LP_RELOAD = CW'(HOLD_CYCLES - 1);

  logic [0:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [7:0]    r_y;
  logic          r_pend_valid;
  logic [2:0]    r_pend_code;

  logic          w_accept;
  logic          w_last;
  logic [0:0]    w_state_nx;
  logic [CW-1:0] w_cnt_nx;
  logic [7:0]    w_y_nx;
  logic          w_pend_valid_nx;
  logic [2:0]    w_pend_code_nx;

  function automatic logic [7:0] onehot(input logic [2:0] code);
    onehot = 8'b0000_0001 << code;
  endfunction

  // in_ready depends only on the pending register, so there is no
  // combinational path from in_valid back to in_ready.
  assign w_accept = in_valid & ~r_pend_valid;
  assign w_last   = (r_state == S_HOLD) && (r_cnt == '0);

  always_comb begin
    w_state_nx      = r_state;
    w_cnt_nx        = r_cnt;
    w_y_nx          = r_y;
    w_pend_valid_nx = r_pend_valid;
    w_pend_code_nx  = r_pend_code;

    if (clr) begin
      // Abort wins over everything, including an accept in this cycle.
      w_state_nx      = S_IDLE;
      w_cnt_nx        = '0;
      w_y_nx          = '0;
      w_pend_valid_nx = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            w_state_nx = S_HOLD;
            w_cnt_nx   = LP_RELOAD;
            w_y_nx     = onehot(in_code);
          end
        end
        S_HOLD: begin
          if (!w_last) begin
            w_cnt_nx = r_cnt - 1'b1;
            if (w_accept) begin
              w_pend_valid_nx = 1'b1;
              w_pend_code_nx  = in_code;
            end
          end else if (r_pend_valid) begin
            // Pending code follows the current one with no idle gap.
            w_cnt_nx        = LP_RELOAD;
            w_y_nx          = onehot(r_pend_code);
            w_pend_valid_nx = 1'b0;
          end else if (w_accept) begin
            // Buffer empty on the last cycle: new code bypasses the buffer.
            w_cnt_nx = LP_RELOAD;
            w_y_nx   = onehot(in_code);
          end else begin
            w_state_nx = S_IDLE;
            w_cnt_nx   = '0;
            w_y_nx     = '0;
          end
        end
        default: begin
          w_state_nx      = S_IDLE;
          w_cnt_nx        = '0;
          w_y_nx          = '0;
          w_pend_valid_nx = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_y          <= '0;
      r_pend_valid <= 1'b0;
      r_pend_code  <= '0;
    end else begin
      r_state      <= w_state_nx;
      r_cnt        <= w_cnt_nx;
      r_y          <= w_y_nx;
      r_pend_valid <= w_pend_valid_nx;
      r_pend_code  <= w_pend_code_nx;
    end
  end

  assign in_ready = ~r_pend_valid;
  assign y        = r_y;
  assign y_valid  = (r_state == S_HOLD);
  assign done     = w_last;

endmodule

// File: tb/tb_decoder_3_8_seq.sv
module tb_decoder_3_8_seq;

  localparam int HA = 4;
  localparam int HB = 1;

  logic       clk;
  logic       rst_n = 1'b1;
  logic       vld  [2];
  logic [2:0] cd   [2];
  logic       clrv [2];
  logic       rdo  [2];
  logic [7:0] yo   [2];
  logic       yvo  [2];
  logic       dno  [2];

  int n_vec = 0;
  int n_err = 0;

  decoder_3_8_seq #(.HOLD_CYCLES(HA), .CW(8)) u_a (
    .clk(clk), .rst_n(rst_n), .clr(clrv[0]), .in_valid(vld[0]), .in_code(cd[0]),
    .in_ready(rdo[0]), .y(yo[0]), .y_valid(yvo[0]), .done(dno[0]));

  decoder_3_8_seq #(.HOLD_CYCLES(HB), .CW(8)) u_b (
    .clk(clk), .rst_n(rst_n), .clr(clrv[1]), .in_valid(vld[1]), .in_code(cd[1]),
    .in_ready(rdo[1]), .y(yo[1]), .y_valid(yvo[1]), .done(dno[1]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Behavioural model: every accepted code is logged in order; the output
  // shows the oldest unshown code for H cycles. Anything logged but not yet
  // shown is "waiting", and the block is ready only when nothing waits.
  logic [2:0] alog [2][0:1023];
  int         wr   [2];
  int         rd   [2];
  int         rem  [2];
  bit         act  [2];
  logic [2:0] cur  [2];

  initial begin
    for (int i = 0; i < 2; i++) begin
      wr[i] = 0; rd[i] = 0; rem[i] = 0; act[i] = 0; cur[i] = '0;
    end
    forever begin
      @(posedge clk or negedge rst_n);
      for (int i = 0; i < 2; i++) begin
        bit acc;
        if (!rst_n || clrv[i]) begin
          act[i] = 0; rem[i] = 0; rd[i] = wr[i];
        end else begin
          acc = vld[i] && (wr[i] == rd[i]);
          if (act[i]) begin
            rem[i]--;
            if (rem[i] == 0) act[i] = 0;
          end
          if (acc) begin
            alog[i][wr[i] % 1024] = cd[i];
            wr[i]++;
          end
          if (!act[i] && rd[i] != wr[i]) begin
            cur[i] = alog[i][rd[i] % 1024];
            rd[i]++;
            act[i] = 1;
            rem[i] = (i == 0) ? HA : HB;
          end
        end
      end
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        logic [7:0] ey;
        ey = act[i] ? (8'd1 << cur[i]) : 8'd0;
        chk($sformatf("m%0d_y", i), 32'(yo[i]), 32'(ey));
        chk($sformatf("m%0d_yv", i), 32'(yvo[i]), 32'(act[i]));
        chk($sformatf("m%0d_done", i), 32'(dno[i]), 32'(act[i] && rem[i] == 1));
        chk($sformatf("m%0d_rdy", i), 32'(rdo[i]), 32'(wr[i] == rd[i]));
      end
    end
  end

  logic [7:0] rec_q [$];
  bit         rec_en = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (rec_en) rec_q.push_back(yo[0]);
    end
  end

  // Called at a falling edge; returns at the falling edge after the accept,
  // i.e. the first held cycle. in_valid is left asserted.
  task automatic send(input int i, input logic [2:0] c);
    int g;
    vld[i] = 1'b1;
    cd[i]  = c;
    g = 0;
    while (rdo[i] !== 1'b1 && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (g >= 50) begin
      n_vec++; n_err++;
      $display("FAIL send_timeout: in_ready stuck at %b, required 1", rdo[i]);
    end
    @(negedge clk);
  endtask

  task automatic wait_idle(input int i);
    int g;
    g = 0;
    while (yvo[i] !== 1'b0 && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (g >= 50) begin
      n_vec++; n_err++;
      $display("FAIL idle_timeout: y_valid stuck at %b, required 0", yvo[i]);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      vld[i] = 1'b0; cd[i] = '0; clrv[i] = 1'b0;
    end

    // Reset / idle
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_y", 32'(yo[0]), 32'h00);
    chk("rst_yv", 32'(yvo[0]), 32'h0);
    chk("rst_done", 32'(dno[0]), 32'h0);
    chk("rst_rdy", 32'(rdo[0]), 32'h1);

    // Full sweep, one code at a time
    for (int c = 0; c < 8; c++) begin
      logic [2:0] cc;
      cc = 3'(c);
      send(0, cc);
      vld[0] = 1'b0;
      for (int k = 0; k < 4; k++) begin
        if (k > 0) @(negedge clk);
        chk($sformatf("sweep%0d_y%0d", c, k), 32'(yo[0]), 32'(8'd1 << cc));
        chk($sformatf("sweep%0d_done%0d", c, k), 32'(dno[0]), 32'(k == 3));
      end
      @(negedge clk);
      chk($sformatf("sweep%0d_rel", c), 32'(yo[0]), 32'h00);
    end
    chk("sweep_last_lit", 32'(8'd1 << 3'd7), 32'h80);

    // Back-to-back 3,5,6 with in_valid held high
    rec_q.delete();
    rec_en = 1;
    send(0, 3'd3);
    chk("b2b_y3", 32'(yo[0]), 32'h08);
    send(0, 3'd5);
    chk("b2b_rdy_full", 32'(rdo[0]), 32'h0);
    send(0, 3'd6);
    vld[0] = 1'b0;
    wait_idle(0);
    @(negedge clk);
    rec_en = 0;
    begin
      int idx;
      idx = 0;
      while (idx < rec_q.size() && rec_q[idx] == 8'h00) idx++;
      if (idx + 12 >= rec_q.size()) begin
        n_vec++; n_err++;
        $display("FAIL b2b_len: got %0d samples, required at least %0d", rec_q.size(), idx + 13);
      end else begin
        for (int j = 0; j < 12; j++)
          chk($sformatf("b2b_seq%0d", j), 32'(rec_q[idx + j]),
              (j < 4) ? 32'h08 : (j < 8) ? 32'h20 : 32'h40);
        chk("b2b_end", 32'(rec_q[idx + 12]), 32'h00);
      end
    end

    // Boundary accept on the last hold cycle with the buffer empty
    send(0, 3'd1);
    vld[0] = 1'b0;
    repeat (3) @(negedge clk);
    chk("bnd_done", 32'(dno[0]), 32'h1);
    chk("bnd_old", 32'(yo[0]), 32'h02);
    vld[0] = 1'b1;
    cd[0]  = 3'd2;
    @(negedge clk);
    vld[0] = 1'b0;
    chk("bnd_new", 32'(yo[0]), 32'h04);
    wait_idle(0);

    // Abort mid-hold of 7 with 1 pending
    send(0, 3'd7);
    cd[0] = 3'd1;
    @(negedge clk);
    vld[0] = 1'b0;
    chk("clr_pend_rdy", 32'(rdo[0]), 32'h0);
    clrv[0] = 1'b1;
    @(negedge clk);
    clrv[0] = 1'b0;
    chk("clr_y", 32'(yo[0]), 32'h00);
    chk("clr_yv", 32'(yvo[0]), 32'h0);
    chk("clr_rdy", 32'(rdo[0]), 32'h1);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk($sformatf("clr_quiet%0d", k), 32'(yo[0]), 32'h00);
    end

    // HOLD_CYCLES=1 stream 4,0,1
    send(1, 3'd4);
    chk("h1_y4", 32'(yo[1]), 32'h10);
    chk("h1_d4", 32'(dno[1]), 32'h1);
    cd[1] = 3'd0;
    @(negedge clk);
    chk("h1_y0", 32'(yo[1]), 32'h01);
    chk("h1_d0", 32'(dno[1]), 32'h1);
    cd[1] = 3'd1;
    @(negedge clk);
    vld[1] = 1'b0;
    chk("h1_y1", 32'(yo[1]), 32'h02);
    chk("h1_d1", 32'(dno[1]), 32'h1);
    @(negedge clk);
    chk("h1_rel", 32'(yo[1]), 32'h00);

    // Asynchronous reset mid-stream
    send(1, 3'd3);
    chk("ar_pre", 32'(yo[1]), 32'h08);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_y", 32'(yo[1]), 32'h00);
    chk("ar_yv", 32'(yvo[1]), 32'h0);
    chk("ar_done", 32'(dno[1]), 32'h0);
    vld[1] = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("ar_after%0d", k), 32'(yo[1]), 32'h00);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/decoder_3_8_seq.md
Name: decoder_3_8_seq

Overview:
- Registered, handshaked 3-to-8 one-hot decoder; the inverse of the team's 8-to-3 encoder.
- Accepts a 3-bit code and drives the matching one-hot output bit for HOLD_CYCLES clock cycles, then releases it.
- A one-entry pending buffer lets upstream queue the next code while the current one is held, so back-to-back codes produce gap-free output.
- Sits between a code source (e.g. encoder output or control FSM) and one-hot select/strobe lines.

Parameters:
- HOLD_CYCLES, 4: number of cycles each decoded one-hot value is held on y; legal range 1..255.
- CW, 8: width of the internal hold counter; must satisfy 2^CW > HOLD_CYCLES.

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- clr  input  1  synchronous abort: drops the held output and the pending code.
- in_valid  input  1  upstream presents a code on in_code.
- in_code  input  3  binary code to decode.
- in_ready  output  1  block can accept a code this cycle.
- y  output  8  registered one-hot output; bit in_code is set.
- y_valid  output  1  high whenever y is non-zero (a code is being held).
- done  output  1  one-cycle pulse during the last hold cycle of each code.

Behaviour:
- Reset (rst_n low, asynchronous): y=8'h00, y_valid=0, done=0, pending buffer empty, hold counter=0, state=IDLE. in_ready is 1 whenever rst_n is high and the pending buffer is empty.
- Accept: the handshake occurs on a rising edge with in_valid=1 and in_ready=1. in_code is sampled only on accept. in_ready = !pend_valid; it is driven from a register only and has no combinational path from in_valid.
- States: IDLE (y=0) and HOLD (y one-hot).
- IDLE, accept at edge k: from edge k+1, y = 1<<in_code, y_valid=1, cnt=HOLD_CYCLES-1, state=HOLD. Latency is 1 cycle.
- HOLD, cnt>0: cnt decrements each cycle and y is stable. An accept in this state writes the pending buffer, so in_ready drops the next cycle.
- HOLD, cnt==0 (last cycle): done=1 for this cycle. At the next edge:
  - pending buffer full: y = 1<<pend_code, cnt=HOLD_CYCLES-1, buffer emptied, state stays HOLD (no gap).
  - buffer empty with a simultaneous accept: the code bypasses the buffer straight into y (no gap); state stays HOLD.
  - otherwise: y=0, y_valid=0, state=IDLE.
- HOLD_CYCLES=1: cnt is always 0 in HOLD, so done is high every held cycle and each code lasts exactly 1 cycle; a continuous stream gives one code per cycle.
- Throughput: at most one accept per cycle. With the buffer full, in_ready stays 0 until the held code finishes. No code is dropped or reordered except by clr or reset.
- clr=1 at an edge: y=0, y_valid=0, done=0, buffer emptied, state=IDLE. Any accept in that same cycle is discarded. clr has priority over all other updates.
- Reset mid-hold: all state is cleared immediately (asynchronously); nothing resumes after release.
- y is always all-zero or exactly one-hot, never multi-hot. y_valid == |y at all times.

Test Plan:
- Reset/idle: rst_n=0 for 2 cycles, then release -> y=00000000, y_valid=0, done=0, in_ready=1.
- Full sweep, HOLD_CYCLES=4: send codes 0..7 one at a time, waiting for IDLE between codes -> y shows 00000001, 00000010 ... 10000000, each for exactly 4 cycles, starting 1 cycle after accept; done pulses on the 4th cycle of each.
- Back-to-back: hold in_valid=1 with codes 3,5,6 -> y = 00001000 for 4 cycles, then 00100000 for 4, then 01000000 for 4, with no zero cycles. in_ready=0 while the buffer is full.
- Boundary accept: with the buffer empty, assert in_valid with code 2 exactly on the cnt==0 cycle -> y goes from the old value straight to 00000100 the next cycle.
- Abort: mid-hold of code 7 with code 1 pending, pulse clr -> y=0 the next cycle, state IDLE, code 1 never appears, in_ready=1.
- HOLD_CYCLES=1 plus async reset: stream codes 4,0,1 -> y = 00010000, 00000001, 00000010 on consecutive cycles with done high each cycle. Pulse rst_n low mid-stream -> y clears immediately, without waiting for a clock edge.
